// File: rtl/arb_pkg.sv
// Shared definitions for the 8-requester arbiter: sizes, FSM state encoding,
// the default hold limit and a one-hot helper.
package arb_pkg;

    localparam int N_REQ            = 8;
    localparam int ID_W             = 3;
    localparam int MAX_HOLD_DEFAULT = 15;
    localparam int HOLD_W           = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] one;
        one = {{(N_REQ-1){1'b0}}, 1'b1};
        return one << id;
    endfunction

endpackage

// File: rtl/arb_prio_enc.sv
// Combinational winner search over 8 requests. UPWARD=1 scans upward starting
// just after ptr (round robin); UPWARD=0 scans downward starting at ptr itself.
module arb_prio_enc
    import arb_pkg::*;
#(
    parameter bit UPWARD = 1'b1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    logic [ID_W-1:0] cand;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // Index arithmetic wraps naturally in ID_W bits (modulo 8).
            if (UPWARD) begin
                cand = ptr + ID_W'(i + 1);
            end else begin
                cand = ptr - ID_W'(i);
            end
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/arbiter_8req.sv
// Eight-requester arbiter with bounded grant length. Define ARB_ROUND_ROBIN_EN
// for round-robin selection; otherwise the highest asserted index wins.
module arbiter_8req
    import arb_pkg::*;
#(
    parameter int N_REQ    = arb_pkg::N_REQ,
    parameter int MAX_HOLD = arb_pkg::MAX_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [ID_W-1:0]   gnt_id_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic              gnt_valid_nxt;
    logic              timeout_nxt;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nxt;

    logic [ID_W-1:0]   enc_ptr;
    logic [ID_W-1:0]   win_id;
    logic              win_valid;

    logic              owner_drop;
    logic              hold_hit;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_nxt;

    assign enc_ptr = ptr;

    arb_prio_enc #(.UPWARD(1'b1)) u_enc (
        .req   (req),
        .ptr   (enc_ptr),
        .idx   (win_id),
        .valid (win_valid)
    );
`else
    // Downward scan from the top index gives fixed highest-index priority.
    assign enc_ptr = ID_W'(N_REQ - 1);

    arb_prio_enc #(.UPWARD(1'b0)) u_enc (
        .req   (req),
        .ptr   (enc_ptr),
        .idx   (win_id),
        .valid (win_valid)
    );
`endif

    assign owner_drop = !req[gnt_id];
    assign hold_hit   = (hold == HOLD_W'(MAX_HOLD));

    always_comb begin
        state_nxt     = state;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        hold_nxt      = hold;
        timeout_nxt   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_nxt       = ptr;
`endif
        case (state)
            IDLE: begin
                gnt_id_nxt    = '0;
                gnt_valid_nxt = 1'b0;
                hold_nxt      = '0;
                if (e && win_valid) begin
                    state_nxt     = GRANT;
                    gnt_id_nxt    = win_id;
                    gnt_valid_nxt = 1'b1;
                    hold_nxt      = HOLD_W'(1);
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_nxt       = win_id;
`endif
                end
            end
            GRANT: begin
                if (!e || done || owner_drop || hold_hit) begin
                    state_nxt     = RELEASE;
                    gnt_id_nxt    = '0;
                    gnt_valid_nxt = 1'b0;
                    hold_nxt      = '0;
                    // Flag a forced release only when the hold limit is the sole cause.
                    timeout_nxt   = hold_hit && e && !done && !owner_drop;
                end else begin
                    hold_nxt = hold + HOLD_W'(1);
                end
            end
            RELEASE: begin
                state_nxt     = IDLE;
                gnt_id_nxt    = '0;
                gnt_valid_nxt = 1'b0;
                hold_nxt      = '0;
            end
            default: begin
                state_nxt     = IDLE;
                gnt_id_nxt    = '0;
                gnt_valid_nxt = 1'b0;
                hold_nxt      = '0;
            end
        endcase
        gnt_nxt = gnt_valid_nxt ? id_to_onehot(gnt_id_nxt) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold      <= '0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
            hold      <= hold_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer starts at 7 so the first search after reset begins at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= ID_W'(N_REQ - 1);
        end else begin
            ptr <= ptr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_arbiter_8req.sv
// Directed scoreboard bench for arbiter_8req; expectations adapt to ARB_ROUND_ROBIN_EN.
module tb_arbiter_8req;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       e = 1'b0;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        logic [2:0] id;
        logic       valid;
        logic       to;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    arbiter_8req #(.N_REQ(8), .MAX_HOLD(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .e         (e),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        cmp({tag, ".gnt"}, gnt, 8'h00);
        cmp({tag, ".gnt_id"}, {5'd0, gnt_id}, 8'h00);
        cmp({tag, ".gnt_valid"}, {7'd0, gnt_valid}, 8'h00);
        cmp({tag, ".timeout"}, {7'd0, timeout}, 8'h00);
    endtask

    task automatic step(input logic e_i, input logic [7:0] req_i, input logic done_i,
                        input logic [2:0] id_x, input logic v_x, input logic to_x,
                        input string tag);
        exp_t x;
        exp_t y;
        logic [7:0] one;
        e    = e_i;
        req  = req_i;
        done = done_i;
        x.id = id_x;
        x.valid = v_x;
        x.to = to_x;
        x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        one = 8'd1;
        cmp({y.tag, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, y.valid});
        cmp({y.tag, ".gnt_id"}, {5'd0, gnt_id}, {5'd0, y.id});
        cmp({y.tag, ".gnt"}, gnt, y.valid ? (one << y.id) : 8'h00);
        cmp({y.tag, ".timeout"}, {7'd0, timeout}, {7'd0, y.to});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] id;

        // Power-up reset
        #1 rst = 1'b1;
        #2 check_idle_outputs("reset_async");
        @(posedge clk);
        #1 check_idle_outputs("reset_held");
        rst = 1'b0;

        // All requests held, done every third cycle
        for (int k = 0; k < 9; k++) begin
            id = RR ? 3'(k % 8) : 3'd7;
            step(1'b1, 8'hFF, 1'b0, id, 1'b1, 1'b0, "seq_grant");
            step(1'b1, 8'hFF, 1'b0, id, 1'b1, 1'b0, "seq_hold");
            step(1'b1, 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0, "seq_release");
            step(1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0, "seq_idle");
        end

        // Reset between clock edges during a grant
        step(1'b1, 8'hFF, 1'b0, RR ? 3'd1 : 3'd7, 1'b1, 1'b0, "pre_reset_grant");
        #2 rst = 1'b1;
        #1 check_idle_outputs("reset_mid_grant");
        #2 rst = 1'b0;
        step(1'b1, 8'hFF, 1'b0, RR ? 3'd0 : 3'd7, 1'b1, 1'b0, "post_reset_grant");
        step(1'b1, 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0, "post_reset_release");
        step(1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "post_reset_idle");
        step(1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "no_req_idle");

        // Mixed request pattern, done release, then the lower requester
        step(1'b1, 8'h26, 1'b0, RR ? 3'd1 : 3'd5, 1'b1, 1'b0, "mix_grant");
        step(1'b1, 8'h26, 1'b0, RR ? 3'd1 : 3'd5, 1'b1, 1'b0, "mix_hold");
        step(1'b1, 8'h26, 1'b1, 3'd0, 1'b0, 1'b0, "mix_release");
        step(1'b1, 8'h06, 1'b0, 3'd0, 1'b0, 1'b0, "mix_idle");
        step(1'b1, 8'h06, 1'b0, 3'd2, 1'b1, 1'b0, "mix_regrant2");

        // Owner drops its request
        step(1'b1, 8'h02, 1'b0, 3'd0, 1'b0, 1'b0, "drop_release");
        step(1'b1, 8'h02, 1'b0, 3'd0, 1'b0, 1'b0, "drop_idle");
        step(1'b1, 8'h02, 1'b0, 3'd1, 1'b1, 1'b0, "drop_regrant1");

        // Enable removed during a grant, then held off
        step(1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0, "en_off_release");
        step(1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0, "en_off_idle0");
        step(1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0, "en_off_idle1");
        step(1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0, "en_off_idle2");

        // Hold limit: done in IDLE is ignored, 15 grant cycles then timeout
        step(1'b1, 8'h01, 1'b1, 3'd0, 1'b1, 1'b0, "to_grant_done_ignored");
        for (int i = 2; i <= 15; i++) begin
            step(1'b1, 8'h01, 1'b0, 3'd0, 1'b1, 1'b0, "to_hold");
        end
        step(1'b1, 8'h01, 1'b0, 3'd0, 1'b0, 1'b1, "to_pulse");
        step(1'b1, 8'h01, 1'b0, 3'd0, 1'b0, 1'b0, "to_idle");
        step(1'b1, 8'h01, 1'b0, 3'd0, 1'b1, 1'b0, "to_regrant");

        // Done coincides with the hold limit
        for (int i = 2; i <= 15; i++) begin
            step(1'b1, 8'h01, 1'b0, 3'd0, 1'b1, 1'b0, "tie_hold");
        end
        step(1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 1'b0, "tie_release_no_to");
        step(1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 1'b0, "tie_done_in_release");
        step(1'b1, 8'h01, 1'b0, 3'd0, 1'b1, 1'b0, "tie_regrant");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arbiter_8req.md
ARBITER_8REQ -- requirements
Module: arbiter_8req

Interface
REQ-001 SHALL have parameter N_REQ, default 8, number of requesters (fixed at 8 for this release).
REQ-002 SHALL have parameter MAX_HOLD, default 15, maximum grant length in cycles before forced release; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state rising-edge triggered.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port e  input  1  arbiter enable.
REQ-006 SHALL have port req  input  8  per-requester request, level-sensitive.
REQ-007 SHALL have port done  input  1  current owner releases the resource; single-cycle pulse.
REQ-008 SHALL have port gnt  output  8  one-hot grant, registered.
REQ-009 SHALL have port gnt_id  output  3  binary index of granted requester, registered.
REQ-010 SHALL have port gnt_valid  output  1  high while any grant is held.
REQ-011 SHALL have port timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.

Function
REQ-012 SHALL implement FSM with states IDLE, GRANT, RELEASE.
REQ-013 IDLE: if e=1 and req!=0, SHALL load winner and enter GRANT; gnt/gnt_id/gnt_valid visible the cycle after req is sampled (latency 1).
REQ-014 IDLE with e=0 or req=0: SHALL stay IDLE, gnt=0, gnt_id=0, gnt_valid=0.
REQ-015 GRANT: SHALL hold gnt, gnt_id constant; hold counter increments each cycle from 1.
REQ-016 GRANT exit to RELEASE on any of: done=1, req[gnt_id]=0, hold counter = MAX_HOLD; done takes precedence over timeout when simultaneous (timeout stays 0).
REQ-017 timeout SHALL pulse for exactly one cycle, the cycle the FSM enters RELEASE due to MAX_HOLD only.
REQ-018 RELEASE: SHALL clear gnt, gnt_valid for exactly one bubble cycle, then return to IDLE; no back-to-back grants without a bubble.
REQ-019 e deasserted in GRANT SHALL force RELEASE next cycle regardless of done.
REQ-020 Requests arriving in GRANT or RELEASE SHALL be held off and considered at the next IDLE arbitration; no request is latched internally.
REQ-021 gnt SHALL always equal one-hot of gnt_id when gnt_valid=1 and all-zero otherwise.
REQ-022 done asserted in IDLE or RELEASE SHALL be ignored.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold counter=0, priority pointer=3'd7.
REQ-024 Reset mid-grant SHALL drop the grant asynchronously without a RELEASE bubble; first post-reset arbitration behaves as after power-up.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN defined: winner is first asserted req searching upward from (last gnt_id + 1) modulo 8; pointer updates on every grant; after reset search starts at index 0.
REQ-026 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, highest asserted index wins (req[7] highest, req[0] lowest); pointer logic absent.

Structure
REQ-027 Package arb_pkg SHALL hold N_REQ, ID_W=3, the FSM state enum, and the MAX_HOLD default.
REQ-028 Winner selection SHALL be a sub-module arb_prio_enc (8-bit request, 3-bit start pointer, 3-bit index, valid), combinational, reused in both configurations with pointer tied to 7 for fixed mode.

Verification
REQ-029 Fixed mode: e=1, req=8'b0010_0110 -> gnt=8'b0010_0000, gnt_id=5 one cycle later; done pulse -> one bubble, then gnt_id=2 if req[5] dropped.
REQ-030 RR mode: req=8'hFF held, done every 3rd cycle -> gnt_id sequence 0,1,2,...,7,0 with one bubble between each.
REQ-031 req=8'h01 held, no done, MAX_HOLD=15 -> gnt_valid high 15 cycles, timeout one-cycle pulse, bubble, regrant to 0.
REQ-032 done and MAX_HOLD reached same cycle -> RELEASE, timeout=0.
REQ-033 e=0 with req=8'hFF -> gnt=0 throughout; e dropped in GRANT -> gnt cleared after 1 cycle.
REQ-034 rst asserted mid-GRANT between clock edges -> all outputs 0 immediately; RR pointer restarts at index 0.
